// File: rtl/display_arbiter.sv
// display_arbiter: shares one 32-bit seven-segment display bus between four
// requesters. Round-robin selection with a minimum dwell per grant, an
// abort when the shown source withdraws, and an operator lock that freezes
// the current grant.
module display_arbiter #(
  parameter int DWELL_CYCLES = 25_000_000,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [127:0] src_data,
  input  logic         lock,
  output logic [31:0]  disp_data,
  output logic [1:0]   disp_src,
  output logic [3:0]   grant,
  output logic         busy,
  output logic         dwell_done
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       ptr, ptr_next;
  logic [1:0]       src_next;
  logic [3:0]       grant_next;
  logic             busy_next;
  logic             done_next;

  logic             found;
  logic [1:0]       winner;
  logic [1:0]       cand;

  // Round-robin search: scan ptr+4 down to ptr+1 so the nearest requester
  // after ptr overwrites the others and wins.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    cand   = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state logic: grant selection, dwell counting, abort and lock.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ptr_next   = ptr;
    src_next   = disp_src;
    grant_next = grant;
    busy_next  = busy;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = SHOW;
          cnt_next   = '0;
          ptr_next   = winner;
          src_next   = winner;
          grant_next = 4'b0001 << winner;
          busy_next  = 1'b1;
        end
      end
      SHOW: begin
        if (!lock) begin
          if (!req[disp_src]) begin
            // Shown source withdrew: re-arbitrate immediately, no pulse.
            cnt_next = '0;
            if (found) begin
              ptr_next   = winner;
              src_next   = winner;
              grant_next = 4'b0001 << winner;
            end else begin
              state_next = IDLE;
              grant_next = 4'b0000;
              busy_next  = 1'b0;
            end
          end else if (cnt == CNT_LAST) begin
            // Dwell expired; the current source is still requesting so a
            // winner always exists (possibly itself).
            done_next  = 1'b1;
            cnt_next   = '0;
            ptr_next   = winner;
            src_next   = winner;
            grant_next = 4'b0001 << winner;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Control state register; ptr resets to 3 so the first search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= 2'd3;
      disp_src   <= 2'd0;
      grant      <= 4'b0000;
      busy       <= 1'b0;
      dwell_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      ptr        <= ptr_next;
      disp_src   <= src_next;
      grant      <= grant_next;
      busy       <= busy_next;
      dwell_done <= done_next;
    end
  end

  // Display data follows the granted source one cycle behind; held when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data <= 32'd0;
    end else if (busy) begin
      disp_data <= src_data[32*disp_src +: 32];
    end
  end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 8-digit seven-segment display between 4 requesters, e.g. PC, instruction register, ALU result and memory read data.
- Round-robin scheduler with a minimum dwell time per source, so that each value stays on the display long enough for a person to read it.
- Drives the 32-bit display data bus of the scan/decode module downstream.
- Adds a lock input so the operator can freeze the currently shown source.

Parameters:
- DWELL_CYCLES, 25_000_000, clock cycles a granted source stays on the display before rotation is considered (≥2).
- CNT_W, 32, width of the dwell counter; must hold DWELL_CYCLES-1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  4  request vector; req[i]=1 means source i wants the display.
- src_data  in  128  packed source data; source i occupies bits [32*i+31:32*i].
- lock  in  1  freeze the current grant while high.
- disp_data  out  32  registered data to the display scan module.
- disp_src  out  2  index of the source currently granted.
- grant  out  4  one-hot grant; all zero when idle.
- busy  out  1  high while in SHOW.
- dwell_done  out  1  one-cycle pulse when a dwell period expires.

Behaviour:
- Reset, asserted asynchronously:
  - grant=0, disp_src=0, disp_data=0, busy=0, dwell_done=0.
  - state=IDLE, dwell counter=0, round-robin pointer ptr=3, so the first search starts at source 0.
- Round-robin search (combinational):
  - Order is ptr+1, ptr+2, ptr+3, ptr, modulo 4.
  - The first i with req[i]=1 wins.
  - ptr is updated to the winner's index whenever a grant is issued.
- IDLE:
  - If req≠0, go to SHOW next cycle with grant=onehot(winner), disp_src=winner, busy=1, counter=0.
  - Otherwise stay; grant=0 and busy=0.
  - disp_data keeps its last value; the display is never blanked by the arbiter.
  - lock has no effect in IDLE.
- SHOW, lock=0:
  - The counter increments each cycle.
  - If req[disp_src] falls, abort: counter=0, and in the same cycle re-run the search. A winner is granted next cycle; no winner means go to IDLE (grant=0, busy=0). No dwell_done on abort.
  - When counter==DWELL_CYCLES-1:
    - Pulse dwell_done for one cycle and reset the counter to 0.
    - Search; the winner (possibly the same source, if it is the only requester) is granted next cycle.
    - If req=0, go to IDLE.
  - Abort has priority over dwell expiry in the same cycle.
- SHOW, lock=1:
  - Counter frozen, grant and disp_src unchanged, no dwell_done.
  - Lock overrides both abort (req drop) and expiry.
  - On lock fall, counting resumes from the frozen value. The abort check applies from the first cycle with lock=0.
- Data path:
  - disp_data <= src_data slice of disp_src every cycle while busy=1.
  - Latency: disp_data reflects a new grant 1 cycle after grant changes.
  - Live source data changes propagate with 1-cycle latency.
- Grant switch timing:
  - The grant change and the counter clear happen on the same edge.
  - There is no cycle where grant has two bits set.
  - There is no idle gap between back-to-back grants.
- req changes on non-granted sources during SHOW do not affect the current dwell.
- Mid-operation reset returns all state to reset values immediately, without waiting for a clock edge.

Test Plan (DWELL_CYCLES=4):
- Reset then req=4'b0001, src_data[31:0]=32'h1234_5678:
  - grant=0001 one cycle after req.
  - disp_data=32'h1234_5678 one cycle later.
  - dwell_done pulses every 4 cycles while req stays high; grant stays 0001.
- req=4'b1111 held, distinct data per source (32'hA0..A3 pattern):
  - Grant rotates 0001→0010→0100→1000→0001, each held exactly 4 cycles.
  - disp_src follows 0,1,2,3; disp_data follows with 1-cycle lag.
- Grant on source 2, drop req[2] at counter=1 with req[3]=1:
  - grant=1000 next cycle, no dwell_done.
  - If req=0 instead: grant=0, busy=0, disp_data holds its last value.
- Grant on source 1 with req=4'b0011, raise lock at counter=2 for 10 cycles, dropping req[1] during lock:
  - grant stays 0010 throughout, no dwell_done.
  - After lock falls, the abort occurs on the first cycle and source 0 is granted.
- Assert rst_n=0 mid-dwell, between clock edges:
  - grant, disp_data, busy clear asynchronously.
  - After release with req=4'b1000, the first grant goes to source 3 (ptr=3 search starts at 0).
- Dwell expiry and req drop of the granted source on the same cycle, other source requesting:
  - Abort path taken: no dwell_done, next source granted next cycle.
